// File: rtl/hosted_npu_csr_regs_if.sv
// AXI-Lite channel bundle (32-bit address/data, 4-bit strobe) between host and CSR block.
// Every channel uses valid/ready: a beat transfers on a rising clk edge where both are high; a source holds its payload stable while valid is high and ready is low.
interface axil_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport m (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport s (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/hosted_npu_csr_regs.sv
// NPU control/status register file behind an AXI-Lite slave: launch controls, sticky status,
// busy-cycle counter and level interrupt. fsm_state exposes {read_state, write_state}.
module hosted_npu_csr_regs #(
    parameter logic [31:0] ID_VALUE = 32'h4E50_5531,
    parameter int          LEN_W    = 24
) (
    input  logic             clk,
    input  logic             srst_n,
    axil_if.s                csr,
    output logic             npu_start,
    output logic [31:0]      npu_base,
    output logic [LEN_W-1:0] npu_len,
    input  logic             npu_busy,
    input  logic             npu_done,
    output logic             irq,
    output logic [2:0]       fsm_state
);
    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_RESP} rd_state_t;

    localparam logic [9:0] IDX_ID     = 10'd0;
    localparam logic [9:0] IDX_CTRL   = 10'd1;
    localparam logic [9:0] IDX_STATUS = 10'd2;
    localparam logic [9:0] IDX_BASE   = 10'd3;
    localparam logic [9:0] IDX_LEN    = 10'd4;
    localparam logic [9:0] IDX_CYCLES = 10'd5;

    wr_state_t   wr_st, wr_next;
    rd_state_t   rd_st, rd_next;
    logic        aw_rdy, w_rdy, ar_rdy, commit;
    logic        aw_hs, w_hs, ar_hs;
    logic [9:0]  aw_idx_q, wr_idx, rd_idx;
    logic [31:0] wdata_q, wr_data, rd_val, rdata_q, len_wide, cycles;
    logic [3:0]  wstrb_q, wr_strb;
    logic [1:0]  bresp_q, rresp_q;
    logic        irq_en, done, start_err;
    logic        unused_addr;

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++)
            if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
        return res;
    endfunction

    assign unused_addr = &{1'b0, csr.awaddr[31:12], csr.awaddr[1:0], csr.araddr[31:12], csr.araddr[1:0]};

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            wr_st <= W_IDLE;
            rd_st <= R_IDLE;
        end else begin
            wr_st <= wr_next;
            rd_st <= rd_next;
        end
    end

    // The commit cycle is the one in which the second of AW/W handshakes.
    always_comb begin
        wr_next = wr_st;
        aw_rdy  = 1'b0;
        w_rdy   = 1'b0;
        commit  = 1'b0;
        case (wr_st)
            W_IDLE: begin
                aw_rdy = 1'b1;
                w_rdy  = 1'b1;
                if (csr.awvalid && csr.wvalid) begin
                    wr_next = W_RESP;
                    commit  = 1'b1;
                end else if (csr.awvalid) begin
                    wr_next = W_HAVE_AW;
                end else if (csr.wvalid) begin
                    wr_next = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                w_rdy = 1'b1;
                if (csr.wvalid) begin
                    wr_next = W_RESP;
                    commit  = 1'b1;
                end
            end
            W_HAVE_W: begin
                aw_rdy = 1'b1;
                if (csr.awvalid) begin
                    wr_next = W_RESP;
                    commit  = 1'b1;
                end
            end
            W_RESP: begin
                if (csr.bready) wr_next = W_IDLE;
            end
            default: wr_next = W_IDLE;
        endcase
    end

    always_comb begin
        rd_next = rd_st;
        ar_rdy  = 1'b0;
        case (rd_st)
            R_IDLE: begin
                ar_rdy = 1'b1;
                if (csr.arvalid) rd_next = R_RESP;
            end
            R_RESP: begin
                if (csr.rready) rd_next = R_IDLE;
            end
            default: rd_next = R_IDLE;
        endcase
    end

    assign aw_hs   = csr.awvalid & aw_rdy;
    assign w_hs    = csr.wvalid & w_rdy;
    assign ar_hs   = csr.arvalid & ar_rdy;
    assign wr_idx  = (wr_st == W_HAVE_AW) ? aw_idx_q : csr.awaddr[11:2];
    assign wr_data = (wr_st == W_HAVE_W) ? wdata_q : csr.wdata;
    assign wr_strb = (wr_st == W_HAVE_W) ? wstrb_q : csr.wstrb;
    assign rd_idx  = csr.araddr[11:2];
    assign len_wide = 32'(npu_len);

    always_comb begin
        rd_val = 32'h0;
        case (rd_idx)
            IDX_ID:     rd_val = ID_VALUE;
            IDX_CTRL:   rd_val = {30'h0, irq_en, 1'b0};
            IDX_STATUS: rd_val = {29'h0, start_err, done, npu_busy};
            IDX_BASE:   rd_val = npu_base;
            IDX_LEN:    rd_val = len_wide;
            IDX_CYCLES: rd_val = cycles;
            default:    rd_val = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            aw_idx_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bresp_q  <= 2'b00;
            rdata_q  <= '0;
            rresp_q  <= 2'b00;
        end else begin
            if (aw_hs) aw_idx_q <= csr.awaddr[11:2];
            if (w_hs) begin
                wdata_q <= csr.wdata;
                wstrb_q <= csr.wstrb;
            end
            if (commit) bresp_q <= (wr_idx <= IDX_CYCLES) ? 2'b00 : 2'b10;
            if (ar_hs) begin
                rdata_q <= (rd_idx <= IDX_CYCLES) ? rd_val : 32'h0;
                rresp_q <= (rd_idx <= IDX_CYCLES) ? 2'b00 : 2'b10;
            end
        end
    end

    // A done pulse is applied after the W1C clear so that set wins on collision.
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            npu_start <= 1'b0;
            npu_base  <= '0;
            npu_len   <= '0;
            irq_en    <= 1'b0;
            done      <= 1'b0;
            start_err <= 1'b0;
            cycles    <= '0;
            irq       <= 1'b0;
        end else begin
            npu_start <= 1'b0;
            irq       <= done & irq_en;
            if (npu_busy && (cycles != 32'hFFFF_FFFF)) cycles <= cycles + 32'd1;
            if (commit && (wr_idx == IDX_CTRL) && wr_strb[0]) begin
                irq_en <= wr_data[1];
                if (wr_data[0]) begin
                    if (!npu_busy) begin
                        npu_start <= 1'b1;
                        cycles    <= '0;
                    end else begin
                        start_err <= 1'b1;
                    end
                end
            end
            if (commit && (wr_idx == IDX_STATUS) && wr_strb[0]) begin
                if (wr_data[1]) done      <= 1'b0;
                if (wr_data[2]) start_err <= 1'b0;
            end
            if (commit && (wr_idx == IDX_BASE)) npu_base <= merge(npu_base, wr_data, wr_strb);
            if (commit && (wr_idx == IDX_LEN)) begin
                npu_len <= LEN_W'(merge(len_wide, wr_data, wr_strb));
            end
            if (npu_done) done <= 1'b1;
        end
    end

    assign csr.awready = aw_rdy;
    assign csr.wready  = w_rdy;
    assign csr.arready = ar_rdy;
    assign csr.bvalid  = (wr_st == W_RESP);
    assign csr.bresp   = bresp_q;
    assign csr.rvalid  = (rd_st == R_RESP);
    assign csr.rdata   = rdata_q;
    assign csr.rresp   = rresp_q;
    assign fsm_state   = {rd_st, wr_st};
endmodule

// File: tb/tb_hosted_npu_csr_regs.sv
// Self-checking bench for hosted_npu_csr_regs: directed host MMIO sequences with a response
// scoreboard, launch/interrupt checks and back-pressure on the write response.
module tb_hosted_npu_csr_regs;
    logic        clk = 1'b0;
    logic        srst_n = 1'b0;
    logic        npu_start;
    logic [31:0] npu_base;
    logic [23:0] npu_len;
    logic        npu_busy = 1'b0;
    logic        npu_done = 1'b0;
    logic        irq;
    logic [2:0]  fsm_state;

    axil_if csr ();

    hosted_npu_csr_regs dut (
        .clk(clk), .srst_n(srst_n), .csr(csr), .npu_start(npu_start), .npu_base(npu_base),
        .npu_len(npu_len), .npu_busy(npu_busy), .npu_done(npu_done), .irq(irq), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int r_cnt = 0;
    int b_cnt = 0;
    int start_cnt = 0;
    logic [33:0] exp_q[$];
    logic [1:0]  bexp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // Response monitor: pops the scoreboard on each completed R or B beat.
    always @(negedge clk) begin
        if (srst_n && csr.rvalid && csr.rready) begin
            r_cnt++;
            if (exp_q.size() == 0) check("r_unexpected", 1, 0);
            else check("rdata_rresp", {csr.rresp, csr.rdata}, exp_q.pop_front());
        end
        if (srst_n && csr.bvalid && csr.bready) begin
            b_cnt++;
            if (bexp_q.size() == 0) check("b_unexpected", 1, 0);
            else check("bresp", csr.bresp, bexp_q.pop_front());
        end
        if (srst_n && npu_start) begin
            start_cnt++;
            check("start_with_bvalid", csr.bvalid, 1);
        end
    end

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp);
        int r0, guard;
        logic ok;
        r0 = r_cnt;
        exp_q.push_back({exp_resp, exp_data});
        csr.araddr = addr;
        csr.arvalid = 1'b1;
        ok = 1'b0;
        guard = 0;
        while (!ok && guard < 50) begin
            @(negedge clk) ok = csr.arready;
            @(posedge clk);
            guard++;
        end
        #1 csr.arvalid = 1'b0;
        if (!ok) check("ar_timeout", 0, 1);
        @(negedge clk) check("r_latency", csr.rvalid, 1);
        guard = 0;
        while (r_cnt == r0 && guard < 50) begin
            @(posedge clk);
            guard++;
        end
        if (r_cnt == r0) check("r_timeout", 0, 1);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int lead, input int hold, input logic pulse_done, input logic [1:0] exp_resp);
        int b0, guard;
        logic a, w, aw_done, w_done;
        b0 = b_cnt;
        bexp_q.push_back(exp_resp);
        csr.awaddr = addr;
        csr.wdata = data;
        csr.wstrb = strb;
        csr.bready = (hold == 0);
        aw_done = 1'b0;
        w_done = 1'b0;
        csr.awvalid = 1'b1;
        if (lead == 0) begin
            csr.wvalid = 1'b1;
            npu_done = pulse_done;
        end
        guard = 0;
        while (!(aw_done && w_done) && guard < 50) begin
            @(negedge clk);
            a = csr.awvalid && csr.awready;
            w = csr.wvalid && csr.wready;
            @(posedge clk);
            #1 npu_done = 1'b0;
            if (w) begin
                csr.wvalid = 1'b0;
                w_done = 1'b1;
            end
            if (a) begin
                csr.awvalid = 1'b0;
                aw_done = 1'b1;
                if (lead > 0) begin
                    repeat (lead - 1) begin
                        @(posedge clk);
                        #1;
                    end
                    csr.wvalid = 1'b1;
                end
            end
            guard++;
        end
        if (!(aw_done && w_done)) check("aw_w_timeout", 0, 1);
        @(negedge clk) check("b_latency", csr.bvalid, 1);
        @(posedge clk);
        #1;
        for (int i = 1; i < hold; i++) begin
            @(negedge clk) check("bready_hold", {csr.bvalid, csr.awready, csr.wready}, 3'b100);
            @(posedge clk);
            #1;
        end
        csr.bready = 1'b1;
        guard = 0;
        while (b_cnt == b0 && guard < 50) begin
            @(posedge clk);
            guard++;
        end
        if (b_cnt == b0) check("b_timeout", 0, 1);
        #1;
    endtask

    logic [31:0] m_base;
    logic [31:0] d;
    logic [3:0]  s;
    int          s0;

    initial begin
        csr.awaddr = '0; csr.awvalid = 1'b0; csr.wdata = '0; csr.wstrb = '0; csr.wvalid = 1'b0;
        csr.bready = 1'b1; csr.araddr = '0; csr.arvalid = 1'b0; csr.rready = 1'b1;
        repeat (3) @(posedge clk);
        #1 srst_n = 1'b1;
        @(negedge clk);
        check("rst_readies", {csr.awready, csr.wready, csr.arready}, 3'b111);
        check("rst_valids", {csr.bvalid, csr.rvalid, csr.bresp, csr.rresp}, 6'b0);
        check("rst_rdata", csr.rdata, 0);
        check("rst_start_irq", {npu_start, irq}, 2'b00);
        check("rst_fsm", fsm_state, 0);
        check("rst_base_len", {npu_base, npu_len}, 56'h0);
        @(posedge clk);
        #1;

        axi_read(32'h0000_0000, 32'h4E50_5531, 2'b00);
        axi_read(32'h0000_1003, 32'h4E50_5531, 2'b00);

        axi_write(32'h0000_000C, 32'hDEAD_BEEF, 4'b0101, 2, 0, 1'b0, 2'b00);
        check("npu_base_port", npu_base, 32'h00AD_00EF);
        axi_read(32'h0000_000C, 32'h00AD_00EF, 2'b00);
        m_base = 32'h00AD_00EF;

        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            m_base = merge(m_base, d, s);
            axi_write(32'h0000_000C, d, s, $urandom_range(0, 2), 0, 1'b0, 2'b00);
            axi_read(32'h0000_000C, m_base, 2'b00);
        end

        axi_write(32'h0000_0010, 32'hFFFF_FFFF, 4'hF, 0, 0, 1'b0, 2'b00);
        axi_read(32'h0000_0010, 32'h00FF_FFFF, 2'b00);
        axi_write(32'h0000_0000, 32'hFFFF_FFFF, 4'hF, 0, 0, 1'b0, 2'b00);
        axi_read(32'h0000_0000, 32'h4E50_5531, 2'b00);

        s0 = start_cnt;
        axi_write(32'h0000_0004, 32'h3, 4'h1, 0, 0, 1'b0, 2'b00);
        check("start_pulses", start_cnt - s0, 1);
        axi_read(32'h0000_0004, 32'h2, 2'b00);
        axi_read(32'h0000_0014, 32'h0, 2'b00);
        npu_busy = 1'b1;
        repeat (10) @(posedge clk);
        #1 npu_busy = 1'b0;
        axi_read(32'h0000_0014, 32'd10, 2'b00);

        npu_done = 1'b1;
        @(posedge clk);
        #1 npu_done = 1'b0;
        @(negedge clk);
        @(negedge clk) check("irq_rise", irq, 1);
        @(posedge clk);
        #1;
        axi_read(32'h0000_0008, 32'h2, 2'b00);
        axi_write(32'h0000_0008, 32'h2, 4'hF, 0, 0, 1'b0, 2'b00);
        @(posedge clk);
        #1;
        @(negedge clk) check("irq_clear", irq, 0);
        @(posedge clk);
        #1;
        axi_read(32'h0000_0008, 32'h0, 2'b00);

        npu_busy = 1'b1;
        s0 = start_cnt;
        axi_write(32'h0000_0004, 32'h1, 4'h1, 0, 0, 1'b0, 2'b00);
        check("no_start_busy", start_cnt - s0, 0);
        axi_read(32'h0000_0008, 32'h5, 2'b00);
        npu_busy = 1'b0;
        axi_write(32'h0000_0008, 32'h4, 4'h1, 0, 0, 1'b0, 2'b00);
        axi_read(32'h0000_0008, 32'h0, 2'b00);

        // Start request without lane-0 strobe must be ignored.
        s0 = start_cnt;
        axi_write(32'h0000_0004, 32'h1, 4'h2, 0, 0, 1'b0, 2'b00);
        check("start_needs_lane0", start_cnt - s0, 0);

        axi_write(32'h0000_0008, 32'h2, 4'h1, 0, 0, 1'b1, 2'b00);
        axi_read(32'h0000_0008, 32'h2, 2'b00);
        axi_write(32'h0000_0008, 32'h2, 4'h1, 1, 0, 1'b0, 2'b00);
        axi_read(32'h0000_0008, 32'h0, 2'b00);

        axi_read(32'h0000_0040, 32'h0, 2'b10);
        axi_write(32'h0000_0040, 32'h1234_5678, 4'hF, 0, 0, 1'b0, 2'b10);
        axi_write(32'h0000_000C, 32'h1357_9BDF, 4'hF, 0, 5, 1'b0, 2'b00);
        axi_read(32'h0000_000C, 32'h1357_9BDF, 2'b00);

        repeat (3) @(posedge clk);
        check("sb_empty", {32'(exp_q.size()), 32'(bexp_q.size())}, 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
